// File: rtl/vga_scan_timing_pkg.sv
// Raster timing defaults and game-window constants shared by the scan timing block
// and the game/renderer side.
package vga_scan_timing_pkg;

  localparam int CNT_W = 10;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int H_VISIBLE_AREA = 224;
  localparam int V_VISIBLE_AREA = 288;

  typedef logic [CNT_W-1:0] cnt_t;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vga_scan_timing_scan_axis.sv
// One raster axis: wrap counter, sync/active/game-window compares and the scaled
// game coordinate, all advanced by en_i.
module scan_axis
  import vga_scan_timing_pkg::*;
#(
  parameter int ACTIVE  = H_ACTIVE_DEF,
  parameter int FP      = H_FP_DEF,
  parameter int SYNC    = H_SYNC_DEF,
  parameter int BP      = H_BP_DEF,
  parameter int WIN_OFF = (H_ACTIVE_DEF - H_VISIBLE_AREA) / 2,
  parameter int WIN_LEN = H_VISIBLE_AREA,
  parameter int SCALE   = 1,
  parameter int COORD_W = clog2_min1(H_VISIBLE_AREA)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  output logic               wrap_o,
  output logic [CNT_W-1:0]   cnt_o,
  output logic               sync_n_o,
  output logic               active_nx_o,
  output logic               win_nx_o,
  output logic [COORD_W-1:0] coord_o
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam int EW    = CNT_W + 1;
  localparam int SUB_W = clog2_min1(SCALE);

  localparam logic [EW-1:0]      LAST_E    = EW'(TOTAL - 1);
  localparam logic [EW-1:0]      ACT_E     = EW'(ACTIVE);
  localparam logic [EW-1:0]      SYNC_LO   = EW'(ACTIVE + FP);
  localparam logic [EW-1:0]      SYNC_HI   = EW'(ACTIVE + FP + SYNC);
  localparam logic [EW-1:0]      WIN_LO    = EW'(WIN_OFF);
  localparam logic [EW-1:0]      WIN_HI    = EW'(WIN_OFF + WIN_LEN * SCALE);
  localparam logic [SUB_W-1:0]   SUB_MAX   = SUB_W'(SCALE - 1);
  localparam logic [COORD_W-1:0] COORD_MAX = COORD_W'(WIN_LEN - 1);

  cnt_t               cnt_q, cnt_d;
  logic [EW-1:0]      cnt_x;
  logic [SUB_W-1:0]   sub_q, sub_d;
  logic [COORD_W-1:0] coord_q, coord_d;
  logic               sync_n_q;
  logic               coord_inc;

  always_comb begin
    wrap_o = en_i && ({1'b0, cnt_q} == LAST_E);
    cnt_d  = cnt_q;
    if (wrap_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + cnt_t'(1);
    end
    cnt_x       = {1'b0, cnt_d};
    active_nx_o = (cnt_x < ACT_E);
    win_nx_o    = (cnt_x >= WIN_LO) && (cnt_x < WIN_HI);

    // Coordinate steps once every SCALE positions; no divider needed.
    sub_d     = sub_q;
    coord_d   = coord_q;
    coord_inc = 1'b0;
    if (en_i) begin
      if (!win_nx_o || (cnt_x == WIN_LO)) begin
        sub_d   = '0;
        coord_d = '0;
      end else if (sub_q == SUB_MAX) begin
        sub_d     = '0;
        coord_inc = 1'b1;
        coord_d   = coord_q + COORD_W'(1);
      end else begin
        sub_d = sub_q + SUB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      sub_q    <= '0;
      coord_q  <= '0;
      sync_n_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      sub_q    <= sub_d;
      coord_q  <= coord_d;
      sync_n_q <= !((cnt_x >= SYNC_LO) && (cnt_x < SYNC_HI));
    end
  end

  a_coord_sat: assert property (@(posedge clk) disable iff (!rst)
    !(coord_inc && (coord_q == COORD_MAX)));

  assign cnt_o    = cnt_q;
  assign sync_n_o = sync_n_q;
  assign coord_o  = coord_q;

endmodule

// File: rtl/vga_scan_timing.sv
// VGA raster timing plus the centred, scaled game-window coordinates and strobes.
// Every output describes the pixel held in phys_x/phys_y during the same clk.
module vga_scan_timing
  import vga_scan_timing_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter int GAME_W     = H_VISIBLE_AREA,
  parameter int GAME_H     = V_VISIBLE_AREA,
  parameter int GAME_SCALE = 1,
  parameter int H_OFF      = (H_ACTIVE - GAME_W * GAME_SCALE) / 2,
  parameter int V_OFF      = (V_ACTIVE - GAME_H * GAME_SCALE) / 2,
  localparam int SX_W      = clog2_min1(GAME_W),
  localparam int SY_W      = clog2_min1(GAME_H)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             vga_pix_stb,
  output logic             hsync,
  output logic             vsync,
  output logic             display_enabled,
  output logic [CNT_W-1:0] phys_x,
  output logic [CNT_W-1:0] phys_y,
  output logic [SX_W-1:0]  sx,
  output logic [SY_W-1:0]  sy,
  output logic             game_pix_stb,
  output logic             frame_stb
);

  localparam int               DIV_W    = clog2_min1(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             div_wrap;
  logic             h_wrap, v_wrap;
  logic             h_act_nx, v_act_nx;
  logic             h_win_nx, v_win_nx;
  logic             stb_q, de_q, gstb_q, fstb_q;

  always_comb begin
    div_wrap = (div_q == DIV_LAST);
    div_d    = div_wrap ? '0 : div_q + DIV_W'(1);
  end

  scan_axis #(
    .ACTIVE (H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
    .WIN_OFF(H_OFF), .WIN_LEN(GAME_W), .SCALE(GAME_SCALE), .COORD_W(SX_W)
  ) u_h_axis (
    .clk        (clk),
    .rst        (rst),
    .en_i       (div_wrap),
    .wrap_o     (h_wrap),
    .cnt_o      (phys_x),
    .sync_n_o   (hsync),
    .active_nx_o(h_act_nx),
    .win_nx_o   (h_win_nx),
    .coord_o    (sx)
  );

  scan_axis #(
    .ACTIVE (V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
    .WIN_OFF(V_OFF), .WIN_LEN(GAME_H), .SCALE(GAME_SCALE), .COORD_W(SY_W)
  ) u_v_axis (
    .clk        (clk),
    .rst        (rst),
    .en_i       (h_wrap),
    .wrap_o     (v_wrap),
    .cnt_o      (phys_y),
    .sync_n_o   (vsync),
    .active_nx_o(v_act_nx),
    .win_nx_o   (v_win_nx),
    .coord_o    (sy)
  );

  // Strobes are registered from the next-state compares so they line up with the counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q  <= '0;
      stb_q  <= 1'b0;
      de_q   <= 1'b0;
      gstb_q <= 1'b0;
      fstb_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      stb_q  <= div_wrap;
      de_q   <= h_act_nx && v_act_nx;
      gstb_q <= div_wrap && h_win_nx && v_win_nx;
      fstb_q <= v_wrap;
    end
  end

  assign vga_pix_stb     = stb_q;
  assign display_enabled = de_q;
  assign game_pix_stb    = gstb_q;
  assign frame_stb       = fstb_q;

endmodule

// File: tb/tb_vga_scan_timing.sv
// Bench for vga_scan_timing: default timing over one line, plus two small-raster
// instances (CLK_DIV=4/scale 2 and CLK_DIV=1/scale 1) over whole frames.
module tb_vga_scan_timing;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;

  // Small raster shared by instances B and C: 48 x 23 total.
  localparam int S_HACT = 32, S_HS_LO = 36, S_HS_HI = 44, S_HTOT = 48;
  localparam int S_VACT = 16, S_VS_LO = 18, S_VS_HI = 20, S_VTOT = 23;

  logic       a_stb, a_hs, a_vs, a_de, a_gs, a_fs;
  logic [9:0] a_px, a_py;
  logic [7:0] a_sx;
  logic [8:0] a_sy;
  logic       b_stb, b_hs, b_vs, b_de, b_gs, b_fs;
  logic [9:0] b_px, b_py;
  logic [2:0] b_sx;
  logic [1:0] b_sy;
  logic       c_stb, c_hs, c_vs, c_de, c_gs, c_fs;
  logic [9:0] c_px, c_py;
  logic [3:0] c_sx;
  logic [2:0] c_sy;

  vga_scan_timing u_a (
    .clk(clk), .rst(rst), .vga_pix_stb(a_stb), .hsync(a_hs), .vsync(a_vs),
    .display_enabled(a_de), .phys_x(a_px), .phys_y(a_py), .sx(a_sx), .sy(a_sy),
    .game_pix_stb(a_gs), .frame_stb(a_fs)
  );

  vga_scan_timing #(
    .CLK_DIV(4), .H_ACTIVE(32), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(16), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .GAME_W(8), .GAME_H(4), .GAME_SCALE(2)
  ) u_b (
    .clk(clk), .rst(rst), .vga_pix_stb(b_stb), .hsync(b_hs), .vsync(b_vs),
    .display_enabled(b_de), .phys_x(b_px), .phys_y(b_py), .sx(b_sx), .sy(b_sy),
    .game_pix_stb(b_gs), .frame_stb(b_fs)
  );

  vga_scan_timing #(
    .CLK_DIV(1), .H_ACTIVE(32), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(16), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .GAME_W(10), .GAME_H(6), .GAME_SCALE(1)
  ) u_c (
    .clk(clk), .rst(rst), .vga_pix_stb(c_stb), .hsync(c_hs), .vsync(c_vs),
    .display_enabled(c_de), .phys_x(c_px), .phys_y(c_py), .sx(c_sx), .sy(c_sy),
    .game_pix_stb(c_gs), .frame_stb(c_fs)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Number of outputs disagreeing with the directly computed value for pixel (x,y).
  function automatic int pix_err(input int x, input int y, input int hoff, input int hlen,
                                 input int voff, input int vlen, input int sc,
                                 input int px, input int py, input int hs, input int vs,
                                 input int de, input int gs, input int fs,
                                 input int sx, input int sy);
    int e  = 0;
    int hw = (x >= hoff && x < hoff + hlen * sc) ? 1 : 0;
    int vw = (y >= voff && y < voff + vlen * sc) ? 1 : 0;
    if (px != x) e++;
    if (py != y) e++;
    if (hs != ((x >= S_HS_LO && x < S_HS_HI) ? 0 : 1)) e++;
    if (vs != ((y >= S_VS_LO && y < S_VS_HI) ? 0 : 1)) e++;
    if (de != ((x < S_HACT && y < S_VACT) ? 1 : 0)) e++;
    if (gs != hw * vw) e++;
    if (fs != ((x == 0 && y == 0) ? 1 : 0)) e++;
    if (sx != (hw != 0 ? (x - hoff) / sc : 0)) e++;
    if (sy != (vw != 0 ? (y - voff) / sc : 0)) e++;
    return e;
  endfunction

  int a_first = 0, a_first_px = -1, a_hs_first = -1, a_hs_clks = 0, a_hs_strb = 0;
  int a_de639 = -1, a_de640 = -1, a_sx209 = -1, a_sx431 = -1, a_sx432 = -1;
  int a_px3200 = -1, a_py3200 = -1, a_gs_line0 = 0;
  int bx = 0, by = 0, b_err = 0, b_spur = 0, b_gs_n = 0, b_hs_strb = 0, b_vs_mask = 0;
  int b_gs_cyc = 0, b_gs_pos = -1, b_fs_n = 0;
  int b_fs_at [2] = '{0, 0};
  longint b_sx_seq = 0, b_sy_seq = 0;
  int cx = 0, cy = 0, c_err = 0, c_spur = 0, c_gap = 0, c_gs_n = 0, c_gs_cyc = 0;
  int c_sx_max = 0, c_sy_max = 0, c_fs_n = 0;
  int c_fs_at [2] = '{0, 0};
  int found = 0, rel_px = -1, rel_py = -1, rel_stb = -1, rel_fs = 0;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_a_cnt",   longint'({a_px, a_py, a_sx, a_sy}), 0);
    check("rst_a_flags", longint'({a_hs, a_vs, a_de, a_stb, a_gs, a_fs}), 48);
    check("rst_b_cnt",   longint'({b_px, b_py, b_sx, b_sy}), 0);
    check("rst_b_flags", longint'({b_hs, b_vs, b_de, b_stb, b_gs, b_fs}), 48);
    check("rst_c_flags", longint'({c_hs, c_vs, c_de, c_stb, c_gs, c_fs}), 48);
    rst = 1'b1;

    for (int i = 0; i < 9000; i++) begin
      @(negedge clk);
      // Instance A: default timing, first line only.
      if (a_stb && a_first == 0) begin
        a_first    = cyc;
        a_first_px = int'(a_px);
      end
      if (cyc <= 3300) begin
        if (a_gs) a_gs_line0++;
        if (!a_hs) begin
          a_hs_clks++;
          if (a_hs_first < 0) a_hs_first = int'(a_px);
          if (a_stb) a_hs_strb++;
        end
        if (a_stb && a_py == 10'd0) begin
          if (a_px == 10'd639) a_de639 = int'(a_de);
          if (a_px == 10'd640) a_de640 = int'(a_de);
          if (a_px == 10'd209) a_sx209 = int'(a_sx);
          if (a_px == 10'd431) a_sx431 = int'(a_sx);
          if (a_px == 10'd432) a_sx432 = int'(a_sx);
        end
      end
      if (cyc == 3200) begin
        a_px3200 = int'(a_px);
        a_py3200 = int'(a_py);
      end

      // Instance B: CLK_DIV=4, scale 2, window x 8..23, y 4..11.
      if (b_stb) begin
        bx++;
        if (bx == S_HTOT) begin
          bx = 0;
          by = (by == S_VTOT - 1) ? 0 : by + 1;
        end
        b_err += pix_err(bx, by, 8, 8, 4, 4, 2, int'(b_px), int'(b_py), int'(b_hs),
                         int'(b_vs), int'(b_de), int'(b_gs), int'(b_fs), int'(b_sx), int'(b_sy));
        if (cyc <= 4416) begin
          if (b_gs) b_gs_n++;
          if (b_gs && by == 4) b_sx_seq = (b_sx_seq << 4) | longint'(b_sx);
          if (bx == 8 && by >= 4 && by <= 11) b_sy_seq = (b_sy_seq << 4) | longint'(b_sy);
          if (!b_vs) b_vs_mask |= (1 << by);
          if (!b_hs && by == 0) b_hs_strb++;
        end
      end else if (b_gs || b_fs) begin
        b_spur++;
      end
      if (b_gs && b_gs_cyc == 0) begin
        b_gs_cyc = cyc;
        b_gs_pos = int'({b_px, b_py, b_sx, b_sy});
      end
      if (b_fs) begin
        if (b_fs_n < 2) b_fs_at[b_fs_n] = cyc;
        b_fs_n++;
      end

      // Instance C: CLK_DIV=1, scale 1, window x 11..20, y 5..10.
      if (!c_stb) c_gap++;
      if (c_stb) begin
        cx++;
        if (cx == S_HTOT) begin
          cx = 0;
          cy = (cy == S_VTOT - 1) ? 0 : cy + 1;
        end
        c_err += pix_err(cx, cy, 11, 10, 5, 6, 1, int'(c_px), int'(c_py), int'(c_hs),
                         int'(c_vs), int'(c_de), int'(c_gs), int'(c_fs), int'(c_sx), int'(c_sy));
      end else if (c_gs || c_fs) begin
        c_spur++;
      end
      if (c_gs) begin
        if (c_gs_cyc == 0) c_gs_cyc = cyc;
        if (cyc <= 1104) c_gs_n++;
        if (int'(c_sx) > c_sx_max) c_sx_max = int'(c_sx);
        if (int'(c_sy) > c_sy_max) c_sy_max = int'(c_sy);
      end
      if (c_fs) begin
        if (c_fs_n < 2) c_fs_at[c_fs_n] = cyc;
        c_fs_n++;
      end
    end

    check("a_first_stb_cyc", a_first, 4);
    check("a_first_stb_px", a_first_px, 1);
    check("a_hsync_start_px", a_hs_first, 656);
    check("a_hsync_low_strobes", a_hs_strb, 96);
    check("a_hsync_low_clks", a_hs_clks, 384);
    check("a_de_px639", a_de639, 1);
    check("a_de_px640", a_de640, 0);
    check("a_sx_px209", a_sx209, 1);
    check("a_sx_px431", a_sx431, 223);
    check("a_sx_px432", a_sx432, 0);
    check("a_gs_line0", a_gs_line0, 0);
    check("a_line_wrap", longint'(a_px3200 * 1000 + a_py3200), 1);

    check("b_model_err", b_err, 0);
    check("b_spurious_pulse", b_spur, 0);
    check("b_first_gs_cyc", b_gs_cyc, 800);
    check("b_first_gs_pos", b_gs_pos, int'({10'd8, 10'd4, 3'd0, 2'd0}));
    check("b_sx_sequence", b_sx_seq, 64'h0011223344556677);
    check("b_sy_sequence", b_sy_seq, 64'h0000000000112233);
    check("b_gs_per_frame", b_gs_n, 128);
    check("b_vsync_lines", b_vs_mask, 32'h000C0000);
    check("b_hsync_low_strobes", b_hs_strb, 8);
    check("b_frame_stb_1", b_fs_at[0], 4416);
    check("b_frame_stb_2", b_fs_at[1], 8832);
    check("b_frame_stb_count", b_fs_n, 2);

    check("c_model_err", c_err, 0);
    check("c_spurious_pulse", c_spur, 0);
    check("c_stb_gaps", c_gap, 0);
    check("c_first_gs_cyc", c_gs_cyc, 251);
    check("c_gs_per_frame", c_gs_n, 60);
    check("c_sx_max", c_sx_max, 9);
    check("c_sy_max", c_sy_max, 5);
    check("c_frame_stb_1", c_fs_at[0], 1104);
    check("c_frame_stb_2", c_fs_at[1], 2208);

    // Mid-frame reset on B at pixel (30,10).
    for (int i = 0; i < 6000 && found == 0; i++) begin
      @(negedge clk);
      if (b_stb && b_px == 10'd30 && b_py == 10'd10) found = 1;
    end
    check("b_mid_reached", found, 1);
    check("b_mid_pre_state", longint'({b_de, b_hs, b_sy}), 15);
    rst = 1'b0;
    #1;
    check("b_mid_rst_cnt", longint'({b_px, b_py, b_sx, b_sy}), 0);
    check("b_mid_rst_flags", longint'({b_hs, b_vs, b_de, b_stb, b_gs, b_fs}), 48);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5000 && rel_fs == 0; i++) begin
      @(negedge clk);
      if (cyc == 4) begin
        rel_px  = int'(b_px);
        rel_py  = int'(b_py);
        rel_stb = int'(b_stb);
      end
      if (b_fs) rel_fs = cyc;
    end
    check("b_rel_first_stb", rel_stb, 1);
    check("b_rel_pos", longint'(rel_px * 1000 + rel_py), 1000);
    check("b_rel_frame_stb", rel_fs, 4416);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
